rs_enc: RTL and testbench

RS_ENC -- requirements
Module: rs_enc

---
 rtl/rs_enc.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_rs_enc.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_enc.sv
// Systematic Reed-Solomon encoder over GF(2^SYMB_WIDTH).
// Message symbols stream through unchanged. The LFSR remainder m(x)*x^R mod g(x)
// follows them, highest degree first. The input uses valid/ready with s_last for
// shortened frames, and the output stage is registered.

package gf_pkg;
    localparam int SYMB_WIDTH = 8;
    localparam logic [SYMB_WIDTH:0] POLY = 9'd285;
    localparam int NQ = (1 << SYMB_WIDTH) - 1;

    // Multiply a field element by alpha and reduce modulo POLY.
    function automatic logic [SYMB_WIDTH-1:0] mul_alpha(input logic [SYMB_WIDTH-1:0] a);
        logic [SYMB_WIDTH:0] t;
        t = {a, 1'b0};
        if (t[SYMB_WIDTH]) begin
            t = t ^ POLY;
        end else begin
            t = t;
        end
        return t[SYMB_WIDTH-1:0];
    endfunction

    // Antilog table: entry e holds alpha^e for e = 0..NQ-1.
    function automatic logic [NQ*SYMB_WIDTH-1:0] gen_exp_tbl();
        logic [NQ*SYMB_WIDTH-1:0] tbl;
        logic [SYMB_WIDTH-1:0]    v;
        tbl = {(NQ*SYMB_WIDTH){1'b0}};
        v   = {{(SYMB_WIDTH-1){1'b0}}, 1'b1};
        for (int e = 0; e < NQ; e++) begin
            tbl[e*SYMB_WIDTH +: SYMB_WIDTH] = v;
            v = mul_alpha(v);
        end
        return tbl;
    endfunction

    // Log table: entry s holds log_alpha(s). Entry 0 is unused and stays 0.
    function automatic logic [(NQ+1)*SYMB_WIDTH-1:0] gen_log_tbl();
        logic [(NQ+1)*SYMB_WIDTH-1:0] tbl;
        logic [SYMB_WIDTH-1:0]        v;
        tbl = {((NQ+1)*SYMB_WIDTH){1'b0}};
        v   = {{(SYMB_WIDTH-1){1'b0}}, 1'b1};
        for (int e = 0; e < NQ; e++) begin
            tbl[int'(v)*SYMB_WIDTH +: SYMB_WIDTH] = SYMB_WIDTH'(e);
            v = mul_alpha(v);
        end
        return tbl;
    endfunction

    function automatic logic [SYMB_WIDTH-1:0] alpha_to_symb(input int e);
        logic [NQ*SYMB_WIDTH-1:0] tbl;
        tbl = gen_exp_tbl();
        return tbl[(e % NQ)*SYMB_WIDTH +: SYMB_WIDTH];
    endfunction

    function automatic logic [SYMB_WIDTH-1:0] symb_to_alpha(input logic [SYMB_WIDTH-1:0] s);
        logic [(NQ+1)*SYMB_WIDTH-1:0] tbl;
        tbl = gen_log_tbl();
        return tbl[int'(s)*SYMB_WIDTH +: SYMB_WIDTH];
    endfunction
endpackage

module rs_enc #(
    parameter int SYMB_WIDTH = gf_pkg::SYMB_WIDTH,
    parameter int N_LEN      = 255,
    parameter int R_LEN      = 16,
    parameter int FCR        = 0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [SYMB_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [SYMB_WIDTH-1:0] m_data,
    output logic                  m_last
);
    localparam int K_LEN = N_LEN - R_LEN;
    localparam int CNT_W = $clog2(N_LEN + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] K_END    = CNT_W'(K_LEN - 1);
    localparam logic [CNT_W-1:0] R_END    = CNT_W'(R_LEN - 1);

    localparam logic [SYMB_WIDTH-1:0] SYM_ZERO = {SYMB_WIDTH{1'b0}};
    localparam logic [SYMB_WIDTH:0]   NQ_EXT   = (SYMB_WIDTH+1)'(gf_pkg::NQ);

    localparam logic [gf_pkg::NQ*SYMB_WIDTH-1:0]     EXP_TBL = gf_pkg::gen_exp_tbl();
    localparam logic [(gf_pkg::NQ+1)*SYMB_WIDTH-1:0] LOG_TBL = gf_pkg::gen_log_tbl();

    // GF product through the log/antilog tables. A zero operand has no log, so it
    // is forced to a zero product.
    function automatic logic [SYMB_WIDTH-1:0] gf_mul_tbl(input logic [SYMB_WIDTH-1:0] a,
                                                         input logic [SYMB_WIDTH-1:0] c);
        logic [SYMB_WIDTH:0]   sum;
        logic [SYMB_WIDTH-1:0] res;
        if ((a == SYM_ZERO) || (c == SYM_ZERO)) begin
            res = SYM_ZERO;
        end else begin
            sum = {1'b0, LOG_TBL[int'(a)*SYMB_WIDTH +: SYMB_WIDTH]}
                + {1'b0, LOG_TBL[int'(c)*SYMB_WIDTH +: SYMB_WIDTH]};
            if (sum >= NQ_EXT) begin
                sum = sum - NQ_EXT;
            end else begin
                sum = sum;
            end
            res = EXP_TBL[int'(sum)*SYMB_WIDTH +: SYMB_WIDTH];
        end
        return res;
    endfunction

    // Generator coefficients g[0..R_LEN-1], lowest degree first. The leading 1 is
    // dropped. g(x) is built by multiplying (x + alpha^(FCR+i)) in one root at a time.
    function automatic logic [R_LEN*SYMB_WIDTH-1:0] gen_poly();
        logic [(R_LEN+1)*SYMB_WIDTH-1:0] c;
        logic [SYMB_WIDTH-1:0]           root;
        c = {{(R_LEN*SYMB_WIDTH){1'b0}}, {{(SYMB_WIDTH-1){1'b0}}, 1'b1}};
        for (int i = 0; i < R_LEN; i++) begin
            root = gf_pkg::alpha_to_symb(FCR + i);
            for (int j = i + 1; j > 0; j--) begin
                c[j*SYMB_WIDTH +: SYMB_WIDTH] = c[(j-1)*SYMB_WIDTH +: SYMB_WIDTH]
                    ^ gf_mul_tbl(c[j*SYMB_WIDTH +: SYMB_WIDTH], root);
            end
            c[0 +: SYMB_WIDTH] = gf_mul_tbl(c[0 +: SYMB_WIDTH], root);
        end
        return c[R_LEN*SYMB_WIDTH-1:0];
    endfunction

    localparam logic [R_LEN*SYMB_WIDTH-1:0] GEN = gen_poly();

    typedef enum logic [0:0] {
        ST_DATA   = 1'b0,
        ST_PARITY = 1'b1
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [CNT_W-1:0]      count_r;
    logic [CNT_W-1:0]      count_nxt_s;
    logic [SYMB_WIDTH-1:0] par_r     [R_LEN];
    logic [SYMB_WIDTH-1:0] par_nxt_s [R_LEN];
    logic [SYMB_WIDTH-1:0] m_data_r;
    logic [SYMB_WIDTH-1:0] m_data_nxt_s;
    logic                  m_valid_r;
    logic                  m_valid_nxt_s;
    logic                  m_last_r;
    logic                  m_last_nxt_s;
    logic [SYMB_WIDTH-1:0] fb_s;
    logic                  slot_free_s;
    logic                  s_fire_s;
    logic                  p_fire_s;
    logic                  data_end_s;
    logic                  par_end_s;

    // The output register can take a new symbol when it is empty or being drained.
    // rstn gates s_ready so that nothing is accepted while reset is held.
    assign slot_free_s = !m_valid_r || m_ready;
    assign s_ready     = rstn && (state_r == ST_DATA) && slot_free_s;
    assign s_fire_s    = s_valid && s_ready;
    assign p_fire_s    = (state_r == ST_PARITY) && slot_free_s;
    assign data_end_s  = s_fire_s && (s_last || (count_r == K_END));
    assign par_end_s   = p_fire_s && (count_r == R_END);

    assign m_valid = m_valid_r;
    assign m_data  = m_data_r;
    assign m_last  = m_last_r;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_DATA;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state: leave DATA on the last message symbol and leave PARITY on the last parity symbol.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_DATA: begin
                if (data_end_s) begin
                    state_nxt_s = ST_PARITY;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (par_end_s) begin
                    state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = ST_PARITY;
                end
            end
            default: state_nxt_s = ST_DATA;
        endcase
    end

    // Datapath next values: LFSR update and pass-through in DATA, shift-out in PARITY.
    always_comb begin
        count_nxt_s   = count_r;
        par_nxt_s     = par_r;
        m_data_nxt_s  = m_data_r;
        m_valid_nxt_s = m_valid_r;
        m_last_nxt_s  = m_last_r;
        fb_s          = s_data ^ par_r[R_LEN-1];
        case (state_r)
            ST_DATA: begin
                if (s_fire_s) begin
                    par_nxt_s[0] = gf_mul_tbl(fb_s, GEN[0 +: SYMB_WIDTH]);
                    for (int i = 1; i < R_LEN; i++) begin
                        par_nxt_s[i] = par_r[i-1] ^ gf_mul_tbl(fb_s, GEN[i*SYMB_WIDTH +: SYMB_WIDTH]);
                    end
                    m_data_nxt_s  = s_data;
                    m_valid_nxt_s = 1'b1;
                    m_last_nxt_s  = 1'b0;
                    if (data_end_s) begin
                        count_nxt_s = CNT_ZERO;
                    end else begin
                        count_nxt_s = count_r + CNT_ONE;
                    end
                end else if (m_ready) begin
                    m_valid_nxt_s = 1'b0;
                    m_last_nxt_s  = 1'b0;
                end else begin
                    m_valid_nxt_s = m_valid_r;
                    m_last_nxt_s  = m_last_r;
                end
            end
            ST_PARITY: begin
                if (p_fire_s) begin
                    m_data_nxt_s  = par_r[R_LEN-1];
                    m_valid_nxt_s = 1'b1;
                    m_last_nxt_s  = par_end_s;
                    for (int i = R_LEN - 1; i > 0; i--) begin
                        par_nxt_s[i] = par_r[i-1];
                    end
                    par_nxt_s[0] = SYM_ZERO;
                    if (par_end_s) begin
                        count_nxt_s = CNT_ZERO;
                        for (int i = 0; i < R_LEN; i++) begin
                            par_nxt_s[i] = SYM_ZERO;
                        end
                    end else begin
                        count_nxt_s = count_r + CNT_ONE;
                    end
                end else begin
                    m_valid_nxt_s = m_valid_r;
                    m_last_nxt_s  = m_last_r;
                end
            end
            default: begin
                count_nxt_s = CNT_ZERO;
            end
        endcase
    end

    // Datapath and output registers. Reset drops any partial codeword.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_r   <= CNT_ZERO;
            m_data_r  <= SYM_ZERO;
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
            for (int i = 0; i < R_LEN; i++) begin
                par_r[i] <= SYM_ZERO;
            end
        end else begin
            count_r   <= count_nxt_s;
            m_data_r  <= m_data_nxt_s;
            m_valid_r <= m_valid_nxt_s;
            m_last_r  <= m_last_nxt_s;
            for (int i = 0; i < R_LEN; i++) begin
                par_r[i] <= par_nxt_s[i];
            end
        end
    end

endmodule

// File: tb/tb_rs_enc.sv
// Bench for rs_enc: a default RS(255,239) instance and an R_LEN=2 instance.
// Expected codewords come from polynomial long division using shift-and-add GF
// arithmetic. Syndromes are also checked on the captured outputs.

module tb_rs_enc;
    localparam int RA = 16;
    localparam int KA = 239;
    localparam int NA = 255;

    typedef logic [7:0] sym_q_t[$];
    typedef struct { logic [7:0] d; logic l; } in_t;
    typedef struct { logic [7:0] d; logic l; int c; } obs_t;
    typedef struct { int len; logic [15:0] msg; logic [31:0] cw; } vec_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic       a_s_valid, a_s_ready, a_s_last, a_m_valid, a_m_ready, a_m_last;
    logic [7:0] a_s_data, a_m_data;
    logic       b_s_valid, b_s_ready, b_s_last, b_m_valid, b_m_ready, b_m_last;
    logic [7:0] b_s_data, b_m_data;

    rs_enc #(.SYMB_WIDTH(8), .N_LEN(255), .R_LEN(16), .FCR(0)) dut (
        .clk(clk), .rstn(rstn),
        .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data), .s_last(a_s_last),
        .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data), .m_last(a_m_last)
    );

    rs_enc #(.SYMB_WIDTH(8), .N_LEN(255), .R_LEN(2), .FCR(0)) dut2 (
        .clk(clk), .rstn(rstn),
        .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data), .s_last(b_s_last),
        .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data), .m_last(b_m_last)
    );

    int total = 0;
    int bad = 0;
    int cyc_cnt = 0;
    int stall_cnt = 0;
    in_t  in_q[$];
    in_t  exp_q[$];
    obs_t got_q[$];
    logic [8:0] b_got_q[$];

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) begin
        if (a_m_valid && a_m_ready) got_q.push_back('{d: a_m_data, l: a_m_last, c: cyc_cnt});
        if (b_m_valid && b_m_ready) b_got_q.push_back({b_m_last, b_m_data});
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'd0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1d) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    // Codeword = message followed by the remainder of m(x)*x^r divided by prod(x + alpha^i).
    function automatic sym_q_t encode(input sym_q_t msg, input int r);
        logic [7:0] g [0:16];
        logic [7:0] root, coef;
        sym_q_t buff, cw;
        for (int j = 0; j <= 16; j++) g[j] = 8'd0;
        g[0] = 8'd1;
        root = 8'd1;
        for (int i = 0; i < r; i++) begin
            for (int j = i + 1; j > 0; j--) g[j] = g[j-1] ^ gmul(g[j], root);
            g[0] = gmul(g[0], root);
            root = gmul(root, 8'd2);
        end
        buff = msg;
        for (int j = 0; j < r; j++) buff.push_back(8'd0);
        for (int i = 0; i < msg.size(); i++) begin
            coef = buff[i];
            if (coef != 8'd0)
                for (int j = 1; j <= r; j++) buff[i+j] = buff[i+j] ^ gmul(coef, g[r-j]);
        end
        cw = msg;
        for (int j = 0; j < r; j++) cw.push_back(buff[msg.size()+j]);
        return cw;
    endfunction

    function automatic bit syn_ok(input sym_q_t cw, input int r);
        logic [7:0] x, s;
        bit ok = 1'b1;
        x = 8'd1;
        for (int i = 0; i < r; i++) begin
            s = 8'd0;
            foreach (cw[k]) s = gmul(s, x) ^ cw[k];
            if (s != 8'd0) ok = 1'b0;
            x = gmul(x, 8'd2);
        end
        return ok;
    endfunction

    task automatic add_frame(input int len, input bit use_last, input bit zeros);
        sym_q_t msg, cw;
        for (int k = 0; k < len; k++) begin
            msg.push_back(zeros ? 8'd0 : 8'($urandom));
            in_q.push_back('{d: msg[k], l: use_last && (k == len - 1)});
        end
        cw = encode(msg, RA);
        foreach (cw[k]) exp_q.push_back('{d: cw[k], l: (k == cw.size() - 1)});
    endtask

    // Drive in_q into the default instance with random valid/ready throttling.
    task automatic run_a(input int vpct, input int rpct, input int max_acc,
                         input int n_exp, input int budget, input string name);
        int cyc = 0;
        int acc = 0;
        stall_cnt = 0;
        while (cyc < budget && ((acc < max_acc && in_q.size() > 0) || got_q.size() < n_exp)) begin
            @(posedge clk); #1;
            a_m_ready = ($urandom_range(99) < rpct);
            if (acc < max_acc && in_q.size() > 0 && $urandom_range(99) < vpct) begin
                a_s_valid = 1'b1; a_s_data = in_q[0].d; a_s_last = in_q[0].l;
            end else begin
                a_s_valid = 1'b0; a_s_data = 8'($urandom); a_s_last = 1'($urandom);
            end
            @(negedge clk);
            if (a_s_valid && a_s_ready) begin
                void'(in_q.pop_front());
                acc++;
            end
            if (a_s_valid && !a_s_ready) stall_cnt++;
            cyc++;
        end
        @(posedge clk); #1;
        a_s_valid = 1'b0; a_s_last = 1'b0; a_m_ready = 1'b1;
        check({name, "_timeout"}, 32'(cyc >= budget), 32'd0);
    endtask

    task automatic compare_a(input string name);
        int nmis = 0;
        int n;
        sym_q_t fr;
        check({name, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (got_q[i].d !== exp_q[i].d || got_q[i].l !== exp_q[i].l) nmis++;
        check({name, "_mismatches"}, nmis, 0);
        foreach (got_q[i]) begin
            fr.push_back(got_q[i].d);
            if (got_q[i].l) begin
                check({name, "_syndrome"}, 32'(syn_ok(fr, RA)), 32'd1);
                fr.delete();
            end
        end
    endtask

    task automatic clear_q();
        in_q.delete(); exp_q.delete(); got_q.delete();
    endtask

    vec_t vecs[5];
    int span;

    initial begin
        a_s_valid = 1'b0; a_s_data = 8'd0; a_s_last = 1'b0; a_m_ready = 1'b1;
        b_s_valid = 1'b0; b_s_data = 8'd0; b_s_last = 1'b0; b_m_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", 32'(a_m_valid), 32'd0);
        check("rst_m_last", 32'(a_m_last), 32'd0);
        check("rst_m_data", 32'(a_m_data), 32'd0);
        check("rst_s_ready", 32'(a_s_ready), 32'd0);
        check("rst_s_ready_b", 32'(b_s_ready), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("post_rst_s_ready", 32'(a_s_ready), 32'd1);

        // R_LEN=2 hand vectors, g(x) = x^2 + 3x + 2
        vecs[0] = '{len: 1, msg: 16'h0100, cw: 32'h01030200};
        vecs[1] = '{len: 1, msg: 16'h0000, cw: 32'h00000000};
        vecs[2] = '{len: 1, msg: 16'h0200, cw: 32'h02060400};
        vecs[3] = '{len: 2, msg: 16'h0100, cw: 32'h01000706};
        vecs[4] = '{len: 1, msg: 16'h8000, cw: 32'h809d1d00};
        for (int v = 0; v < 5; v++) begin
            logic [31:0] gw, lm;
            int w;
            b_got_q.delete();
            for (int k = 0; k < vecs[v].len; k++) begin
                @(posedge clk); #1;
                b_s_valid = 1'b1;
                b_s_data  = vecs[v].msg[15-8*k -: 8];
                b_s_last  = (k == vecs[v].len - 1);
                w = 0;
                @(negedge clk);
                while (!b_s_ready && w < 20) begin @(negedge clk); w++; end
                check($sformatf("vec%0d_accept", v), 32'(w >= 20), 32'd0);
            end
            @(posedge clk); #1;
            b_s_valid = 1'b0; b_s_last = 1'b0;
            repeat (6) @(posedge clk);
            #1;
            gw = 32'd0; lm = 32'd0;
            foreach (b_got_q[i]) begin
                if (i < 4) begin
                    gw[31-8*i -: 8] = b_got_q[i][7:0];
                    lm[i] = b_got_q[i][8];
                end
            end
            check($sformatf("vec%0d_count", v), b_got_q.size(), vecs[v].len + 2);
            check($sformatf("vec%0d_data", v), gw, vecs[v].cw);
            check($sformatf("vec%0d_last", v), lm, 32'd1 << (vecs[v].len + 1));
        end

        // Two all-zero full frames, s_valid held through parity
        clear_q();
        add_frame(KA, 1'b0, 1'b1);
        add_frame(KA, 1'b0, 1'b1);
        run_a(100, 100, 1 << 20, 2 * NA, 2000, "zero");
        check("zero_parity_stall", stall_cnt, RA);
        compare_a("zero");

        // Random full frames back-to-back at full rate
        clear_q();
        for (int f = 0; f < 3; f++) add_frame(KA, 1'b0, 1'b0);
        run_a(100, 100, 1 << 20, 3 * NA, 3000, "full");
        span = (got_q.size() > 0) ? (got_q[got_q.size()-1].c - got_q[0].c) : -1;
        check("full_throughput_span", span, 3 * NA - 1);
        compare_a("full");

        // Throttled shortened frames, s_last on symbol K-1, and a forced-end frame
        clear_q();
        for (int f = 0; f < 4; f++) add_frame($urandom_range(KA, 1), 1'b1, 1'b0);
        add_frame(1, 1'b1, 1'b0);
        add_frame(KA, 1'b1, 1'b0);
        add_frame(KA, 1'b0, 1'b0);
        run_a(60, 50, 1 << 20, exp_q.size(), 20000, "thr");
        compare_a("thr");

        // Reset pulse at message symbol 100, then a clean frame
        clear_q();
        add_frame(KA, 1'b0, 1'b0);
        run_a(100, 100, 100, 0, 400, "midrst");
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        check("midrst_m_valid", 32'(a_m_valid), 32'd0);
        check("midrst_m_data", 32'(a_m_data), 32'd0);
        check("midrst_m_last", 32'(a_m_last), 32'd0);
        check("midrst_s_ready", 32'(a_s_ready), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        clear_q();
        add_frame(KA, 1'b0, 1'b0);
        run_a(80, 80, 1 << 20, NA, 3000, "after_rst");
        compare_a("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
